wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage directly downstream of mem_stage.
- Contains the MEM/WB pipeline register, the MemtoReg writeback mux and the 32-entry architectural register file.
- Register file has two combinational read ports with writeback bypass, consumed by decode.
- Also keeps a retired-instruction counter for debug and performance.

Parameters:
DATA_W, 32, datapath and register width
CNT_W, 32, retired-instruction counter width

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  hold MEM/WB contents; suppress regfile write and retire
flush  input  1  squash the incoming instruction (bubble into MEM/WB)
in_valid  input  1  mem_stage outputs carry a real instruction
ReadData  input  DATA_W  load data from mem_stage
ALUResult  input  DATA_W  ALU result forwarded by mem_stage
WriteReg  input  5  destination register
WBControl  input  2  [1]=MemtoReg, [0]=RegWrite
rs_addr  input  5  read port A address
rt_addr  input  5  read port B address
rs_data  output  DATA_W  read port A data
rt_data  output  DATA_W  read port B data
wb_en  output  1  register-file write occurs on next rising edge
wb_reg  output  5  destination of the pending write
wb_data  output  DATA_W  value of the pending write (forwarding source)
retired_count  output  CNT_W  retired-instruction count

Behaviour:
- Reset, asynchronous, on rst_n low:
  - MEM/WB valid_q=0, WBControl_q=0, data and reg fields 0.
  - All 32 registers = 0. retired_count=0.
  - Outputs: wb_en=0, wb_reg=0, wb_data=0.
  - rs_data and rt_data read 0 for every address.
  - Reset mid-stall or mid-write discards the in-flight instruction; no write happens.
- MEM/WB register, priority flush > stall > load:
  - flush=1: valid_q<=0 and WBControl_q<=0 on the edge. Other fields don't care.
  - stall=1 (flush=0): all fields hold.
  - Otherwise: latch in_valid, ReadData, ALUResult, WriteReg, WBControl.
- Writeback, combinational from the MEM/WB register:
  - wb_data = WBControl_q[1] ? ReadData_q : ALUResult_q.
  - wb_reg = WriteReg_q.
  - wb_en = valid_q & WBControl_q[0] & (WriteReg_q != 0) & !stall.
- Register file:
  - On a rising edge with wb_en=1, regs[wb_reg] <= wb_data.
  - Register 0 is never written and always reads 0.
  - Total latency: an instruction presented by mem_stage at edge N is latched at edge N and written at edge N+1, absent a stall.
- Read ports, combinational:
  - rs_data = (rs_addr==0) ? 0 : (wb_en & wb_reg==rs_addr) ? wb_data : regs[rs_addr]. rt_data likewise.
  - The bypass gives write-before-read in the same cycle.
- Stall semantics:
  - The instruction held in MEM/WB writes and retires exactly once, on the first edge with stall=0.
  - A flush on that edge squashes only the incoming instruction, never the retiring one.
- Retire counter:
  - Increments by 1 on each edge where valid_q=1 and stall=0, whether or not RegWrite is set (stores and branches count).
  - Wraps modulo 2^CNT_W.
  - Simultaneous retire and flush still counts the retiring instruction.

Test Plan:
- Reset: drive rst_n=0 mid-sequence, any inputs -> retired_count=0, wb_en=0, rs_data=rt_data=0 for rs_addr=5, rt_addr=31.
- ALU writeback: in_valid=1, ALUResult=0x00000004, WriteReg=2, WBControl=2'b01:
  - Edge 1: wb_en=1, wb_data=0x4.
  - Edge 2: rs_addr=2 reads 0x4; retired_count=1.
- Load writeback with bypass: ReadData=0x12345678, ALUResult=0x4, WriteReg=3, WBControl=2'b11, rs_addr=3:
  - Before edge 2, rs_data=0x12345678 via bypass.
  - After edge 2, still 0x12345678 from the array.
- Register 0: WriteReg=0, WBControl=2'b01, ALUResult=0xDEADBEEF -> wb_en=0; rs_addr=0 reads 0; retired_count still increments.
- Stall then flush:
  - Latch write of 0xAAAA to r4, then hold stall=1 for 3 cycles -> r4 unchanged, retired_count frozen.
  - Release stall with flush=1 -> r4=0xAAAA, count +1, next valid_q=0.
- Counter wrap: run with CNT_W=4, retire 17 valid instructions -> retired_count=1.
- Non-writing instruction: store with WBControl=2'b00 and in_valid=1 -> no register changes, count +1.

Source files
------------

// File: rtl/wb_stage_if.sv
// Signal bundle between mem_stage/decode and the writeback stage.
// master drives pipeline inputs and read addresses; slave is wb_stage.
interface wb_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
);
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] ReadData;
  logic [DATA_W-1:0] ALUResult;
  logic [4:0]        WriteReg;
  logic [1:0]        WBControl;
  logic [4:0]        rs_addr;
  logic [4:0]        rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              wb_en;
  logic [4:0]        wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]  retired_count;

  modport master (
    output stall, flush, in_valid, ReadData, ALUResult, WriteReg, WBControl, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_en, wb_reg, wb_data, retired_count
  );

  modport slave (
    input  stall, flush, in_valid, ReadData, ALUResult, WriteReg, WBControl, rs_addr, rt_addr,
    output rs_data, rt_data, wb_en, wb_reg, wb_data, retired_count
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, MemtoReg mux, 32x register file with
// bypassed read ports, and a retired-instruction counter.
module wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input logic       clk,
  input logic       rst_n,
  wb_stage_if.slave bus
);

  logic              valid_q;
  logic [1:0]        wbctl_q;
  logic [DATA_W-1:0] read_data_q;
  logic [DATA_W-1:0] alu_result_q;
  logic [4:0]        write_reg_q;
  logic [DATA_W-1:0] regs_q [32];
  logic [CNT_W-1:0]  cnt_q;

  logic              wb_en;
  logic [DATA_W-1:0] wb_data;

  // Flush only clears the control half; the data fields are don't-care once invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      wbctl_q      <= 2'b00;
      read_data_q  <= '0;
      alu_result_q <= '0;
      write_reg_q  <= 5'd0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      wbctl_q <= 2'b00;
    end else if (!bus.stall) begin
      valid_q      <= bus.in_valid;
      wbctl_q      <= bus.WBControl;
      read_data_q  <= bus.ReadData;
      alu_result_q <= bus.ALUResult;
      write_reg_q  <= bus.WriteReg;
    end
  end

  always_comb begin
    wb_data = wbctl_q[1] ? read_data_q : alu_result_q;
    wb_en   = valid_q & wbctl_q[0] & (write_reg_q != 5'd0) & ~bus.stall;
  end

  assign bus.wb_en   = wb_en;
  assign bus.wb_reg  = write_reg_q;
  assign bus.wb_data = wb_data;

  // wb_en already excludes r0, so regs_q[0] stays at its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en) begin
      regs_q[write_reg_q] <= wb_data;
    end
  end

  always_comb begin
    bus.rs_data = regs_q[bus.rs_addr];
    if (bus.rs_addr == 5'd0) begin
      bus.rs_data = '0;
    end else if (wb_en && (write_reg_q == bus.rs_addr)) begin
      bus.rs_data = wb_data;
    end
  end

  always_comb begin
    bus.rt_data = regs_q[bus.rt_addr];
    if (bus.rt_addr == 5'd0) begin
      bus.rt_data = '0;
    end else if (wb_en && (write_reg_q == bus.rt_addr)) begin
      bus.rt_data = wb_data;
    end
  end

  // Every valid instruction leaving MEM/WB retires, writing or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (valid_q && !bus.stall) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.retired_count = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed literal checks plus randomized traffic against a
// behavioural model; a second instance with a 4-bit counter shares the stimulus.
module tb_wb_stage;

  logic clk;
  logic rst_n;

  wb_stage_if #(.DATA_W(32), .CNT_W(32)) bus32 ();
  wb_stage_if #(.DATA_W(32), .CNT_W(4))  bus4 ();

  assign bus4.stall     = bus32.stall;
  assign bus4.flush     = bus32.flush;
  assign bus4.in_valid  = bus32.in_valid;
  assign bus4.ReadData  = bus32.ReadData;
  assign bus4.ALUResult = bus32.ALUResult;
  assign bus4.WriteReg  = bus32.WriteReg;
  assign bus4.WBControl = bus32.WBControl;
  assign bus4.rs_addr   = bus32.rs_addr;
  assign bus4.rt_addr   = bus32.rt_addr;

  wb_stage #(.DATA_W(32), .CNT_W(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  wb_stage #(.DATA_W(32), .CNT_W(4)) u_dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: architectural registers, the instruction waiting to retire, retire total.
  logic [31:0] m_regs [32];
  logic        pend_valid;
  logic        pend_we;
  logic [4:0]  pend_rd;
  logic [31:0] pend_val;
  int unsigned m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    pend_valid = 1'b0;
    pend_we    = 1'b0;
    pend_rd    = 5'd0;
    pend_val   = 32'h0;
    m_cnt      = 0;
  endtask

  function automatic logic model_wen();
    return pend_valid && pend_we && (pend_rd != 5'd0) && !bus32.stall;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (model_wen() && pend_rd == a) return pend_val;
    return m_regs[a];
  endfunction

  task automatic model_check();
    logic [31:0] cnt_now;
    logic [3:0]  cnt_small;
    cnt_now   = m_cnt;
    cnt_small = cnt_now[3:0];
    chk("wb_en", {63'b0, bus32.wb_en}, {63'b0, model_wen()});
    if (pend_valid) begin
      chk("wb_reg", {59'b0, bus32.wb_reg}, {59'b0, pend_rd});
      chk("wb_data", {32'b0, bus32.wb_data}, {32'b0, pend_val});
    end
    chk("rs_data", {32'b0, bus32.rs_data}, {32'b0, exp_read(bus32.rs_addr)});
    chk("rt_data", {32'b0, bus32.rt_data}, {32'b0, exp_read(bus32.rt_addr)});
    chk("retired_count", {32'b0, bus32.retired_count}, {32'b0, cnt_now});
    chk("retired_count_w4", {60'b0, bus4.retired_count}, {60'b0, cnt_small});
    chk("rs_data_w4", {32'b0, bus4.rs_data}, {32'b0, exp_read(bus32.rs_addr)});
  endtask

  // Model of one rising edge, using the inputs that are stable across it.
  task automatic model_step();
    if (model_wen()) m_regs[pend_rd] = pend_val;
    if (pend_valid && !bus32.stall) m_cnt++;
    if (bus32.flush) begin
      pend_valid = 1'b0;
      pend_we    = 1'b0;
    end else if (!bus32.stall) begin
      pend_valid = bus32.in_valid;
      pend_we    = bus32.WBControl[0];
      pend_rd    = bus32.WriteReg;
      pend_val   = bus32.WBControl[1] ? bus32.ReadData : bus32.ALUResult;
    end
  endtask

  // Present inputs at the falling edge, check combinational outputs, then take the rising edge.
  task automatic drive(input logic v, input logic [31:0] rdat, input logic [31:0] alu,
                       input logic [4:0] wr, input logic [1:0] ctl, input logic st,
                       input logic fl, input logic [4:0] ra, input logic [4:0] rb);
    @(negedge clk);
    bus32.in_valid  = v;
    bus32.ReadData  = rdat;
    bus32.ALUResult = alu;
    bus32.WriteReg  = wr;
    bus32.WBControl = ctl;
    bus32.stall     = st;
    bus32.flush     = fl;
    bus32.rs_addr   = ra;
    bus32.rt_addr   = rb;
    #1;
    model_check();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_step();
  endtask

  // Short asynchronous pulse between edges; any in-flight instruction is lost.
  task automatic do_reset();
    #2;
    bus32.rs_addr = 5'd5;
    bus32.rt_addr = 5'd31;
    rst_n = 1'b0;
    #1;
    chk("rst_retired", {32'b0, bus32.retired_count}, 64'd0);
    chk("rst_retired_w4", {60'b0, bus4.retired_count}, 64'd0);
    chk("rst_wb_en", {63'b0, bus32.wb_en}, 64'd0);
    chk("rst_wb_reg", {59'b0, bus32.wb_reg}, 64'd0);
    chk("rst_wb_data", {32'b0, bus32.wb_data}, 64'd0);
    chk("rst_rs_data", {32'b0, bus32.rs_data}, 64'd0);
    chk("rst_rt_data", {32'b0, bus32.rt_data}, 64'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step(input logic v, input logic [31:0] rdat, input logic [31:0] alu,
                      input logic [4:0] wr, input logic [1:0] ctl, input logic st,
                      input logic fl, input logic [4:0] ra, input logic [4:0] rb);
    drive(v, rdat, alu, wr, ctl, st, fl, ra, rb);
    edge_step();
  endtask

  initial begin
    rst_n           = 1'b1;
    bus32.stall     = 1'b0;
    bus32.flush     = 1'b0;
    bus32.in_valid  = 1'b0;
    bus32.ReadData  = 32'h0;
    bus32.ALUResult = 32'h0;
    bus32.WriteReg  = 5'd0;
    bus32.WBControl = 2'b00;
    bus32.rs_addr   = 5'd0;
    bus32.rt_addr   = 5'd0;
    model_reset();
    do_reset();

    // ALU writeback to r2
    step(1'b1, 32'h0, 32'h4, 5'd2, 2'b01, 1'b0, 1'b0, 5'd0, 5'd0);
    drive(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd2, 5'd0);
    chk("alu_wb_en", {63'b0, bus32.wb_en}, 64'd1);
    chk("alu_wb_data", {32'b0, bus32.wb_data}, 64'h4);
    chk("alu_bypass", {32'b0, bus32.rs_data}, 64'h4);
    edge_step();
    // Load writeback to r3, seen through the bypass then the array
    drive(1'b1, 32'h12345678, 32'h4, 5'd3, 2'b11, 1'b0, 1'b0, 5'd2, 5'd3);
    chk("alu_array", {32'b0, bus32.rs_data}, 64'h4);
    chk("alu_count", {32'b0, bus32.retired_count}, 64'd1);
    chk("ld_not_yet", {32'b0, bus32.rt_data}, 64'h0);
    edge_step();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd3, 5'd0);
    chk("ld_bypass", {32'b0, bus32.rs_data}, 64'h12345678);
    chk("ld_wb_data", {32'b0, bus32.wb_data}, 64'h12345678);
    edge_step();
    // Write to r0 is dropped but still retires
    drive(1'b1, 32'h0, 32'hDEADBEEF, 5'd0, 2'b01, 1'b0, 1'b0, 5'd3, 5'd0);
    chk("ld_array", {32'b0, bus32.rs_data}, 64'h12345678);
    chk("ld_count", {32'b0, bus32.retired_count}, 64'd2);
    edge_step();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0);
    chk("r0_wb_en", {63'b0, bus32.wb_en}, 64'd0);
    chk("r0_read", {32'b0, bus32.rs_data}, 64'h0);
    edge_step();
    // Stall for three cycles, then release together with a flush
    step(1'b1, 32'h0, 32'hAAAA, 5'd4, 2'b01, 1'b0, 1'b0, 5'd4, 5'd0);
    chk("r0_count", {32'b0, bus32.retired_count}, 64'd3);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0, 32'h5555, 5'd4, 2'b01, 1'b1, 1'b0, 5'd4, 5'd0);
      chk("stall_wb_en", {63'b0, bus32.wb_en}, 64'd0);
      chk("stall_r4", {32'b0, bus32.rs_data}, 64'h0);
      chk("stall_count", {32'b0, bus32.retired_count}, 64'd3);
      edge_step();
    end
    drive(1'b1, 32'h0, 32'h7777, 5'd4, 2'b01, 1'b0, 1'b1, 5'd4, 5'd0);
    chk("release_wb_en", {63'b0, bus32.wb_en}, 64'd1);
    chk("release_bypass", {32'b0, bus32.rs_data}, 64'hAAAA);
    edge_step();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd4, 5'd0);
    chk("flush_r4", {32'b0, bus32.rs_data}, 64'hAAAA);
    chk("flush_count", {32'b0, bus32.retired_count}, 64'd4);
    chk("flush_bubble", {63'b0, bus32.wb_en}, 64'd0);
    edge_step();
    // Store: retires without touching the register file
    step(1'b1, 32'h0, 32'h1234, 5'd5, 2'b00, 1'b0, 1'b0, 5'd5, 5'd0);
    drive(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd5, 5'd0);
    chk("st_wb_en", {63'b0, bus32.wb_en}, 64'd0);
    edge_step();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd5, 5'd4);
    chk("st_count", {32'b0, bus32.retired_count}, 64'd5);
    chk("st_r5", {32'b0, bus32.rs_data}, 64'h0);
    chk("st_r4", {32'b0, bus32.rt_data}, 64'hAAAA);
    edge_step();

    // 17 retirements wrap the 4-bit counter to 1
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 32'h0, i, 5'd1, 2'b00, 1'b0, 1'b0, 5'd1, 5'd0);
    end
    step(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd1, 5'd0);
    drive(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd1, 5'd0);
    chk("wrap_w4", {60'b0, bus4.retired_count}, 64'd1);
    chk("wrap_w32", {32'b0, bus32.retired_count}, 64'd17);
    edge_step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic       v;
      logic       st;
      logic       fl;
      logic [4:0] wr;
      logic [4:0] ra;
      logic [4:0] rb;
      v  = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 7) == 0);
      wr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ra = ($urandom_range(0, 2) == 0) ? pend_rd : 5'($urandom_range(0, 7));
      rb = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      drive(v, $urandom, $urandom, wr, 2'($urandom_range(0, 3)), st, fl, ra, rb);
      if ($urandom_range(0, 249) == 0) begin
        @(posedge clk);
        do_reset();
      end else begin
        edge_step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
